object_position_tracker: RTL and testbench

//  Frame-rate tracker directly downstream of the colour-centroid locator.

---
 rtl/tracker_pkg.sv | 17 +
 rtl/ema_axis_filter.sv | 97 +++++++++
 rtl/object_position_tracker.sv | 193 +++++++++++++++++++
 tb/tb_object_position_tracker.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tracker_pkg.sv
`timescale 1ns/1ps
// tracker_pkg: types and defaults shared by the object position tracker and its axis filters.
// The VELOCITY_EST_EN macro enables velocity estimation and coast prediction in the axis filters.
package tracker_pkg;

  localparam int POS_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2,
    COAST   = 2'd3
  } trk_state_e;

  typedef logic signed [POS_W_DEFAULT:0] posDiff_t;

endpackage

// File: rtl/ema_axis_filter.sv
`timescale 1ns/1ps
// ema_axis_filter: one coordinate axis of the tracker. It holds the filtered position,
// flags measurements too far from it, and applies the EMA step when told to.
// With VELOCITY_EST_EN defined it also keeps a per-frame velocity and predicts the
// position forward while the tracker is coasting; otherwise vel is tied to zero.
module ema_axis_filter
  import tracker_pkg::*;
#(
  parameter int POS_W       = POS_W_DEFAULT,
  parameter int ALPHA_SHIFT = 2,
  parameter int MAX_JUMP    = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic             emaUpdate,
  input  logic             velUpdate,
  input  logic             predict,
  input  logic             clearVel,
  input  logic [POS_W-1:0] meas,
  output logic             outlier,
  output logic [POS_W-1:0] filt,
  output logic [POS_W:0]   vel
);

  localparam logic signed [POS_W:0] JUMP_LIMIT = (POS_W+1)'(MAX_JUMP);

  logic signed [POS_W:0] filtExt;
  logic signed [POS_W:0] diff;
  logic signed [POS_W:0] absDiff;
  logic signed [POS_W:0] emaNext;

  // Both operands are zero-extended, so the one extra bit holds any signed difference.
  assign filtExt = $signed({1'b0, filt});
  assign diff    = $signed({1'b0, meas}) - filtExt;
  assign absDiff = diff[POS_W] ? -diff : diff;
  assign outlier = absDiff > JUMP_LIMIT;
  assign emaNext = filtExt + (diff >>> ALPHA_SHIFT);

`ifdef VELOCITY_EST_EN
  localparam logic signed [POS_W+1:0] POS_MAX = $signed({2'b00, {POS_W{1'b1}}});

  logic signed [POS_W:0]   velReg;
  logic signed [POS_W+1:0] predSum;
  logic [POS_W-1:0]        predNext;

  assign predSum = $signed({filtExt[POS_W], filtExt}) + $signed({velReg[POS_W], velReg});
  assign vel     = velReg;

  // Coast prediction: step by the last velocity, saturating to the coordinate range.
  always_comb begin
    predNext = predSum[POS_W-1:0];
    if (predSum[POS_W+1]) begin
      predNext = '0;
    end else if (predSum > POS_MAX) begin
      predNext = '1;
    end
  end

  // Velocity is the size of the last tracked EMA step and is forgotten when the lock is dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      velReg <= '0;
    end else if (enable) begin
      if (clearVel) begin
        velReg <= '0;
      end else if (velUpdate) begin
        velReg <= emaNext - filtExt;
      end
    end
  end
`else
  logic unusedVelCtrl;
  assign unusedVelCtrl = ^{velUpdate, predict, clearVel, emaNext[POS_W]};
  assign vel = '0;
`endif

  // Filtered position: seeded on acquisition, smoothed on accepted hits, predicted while coasting.
  always_ff @(posedge clock) begin
    if (reset) begin
      filt <= '0;
    end else if (enable) begin
      if (load) begin
        filt <= meas;
      end else if (emaUpdate) begin
        filt <= emaNext[POS_W-1:0];
      end
`ifdef VELOCITY_EST_EN
      else if (predict) begin
        filt <= predNext;
      end
`endif
    end
  end

endmodule

// File: rtl/object_position_tracker.sv
`timescale 1ns/1ps
// object_position_tracker: once per frame, take the last centroid measurement, run the
// acquire/track/coast/lost state machine, smooth X and Y with EMA filters and publish a
// position strobe two cycles after the frame-end cycle.
// Optional feature: define VELOCITY_EST_EN for velocity outputs and coast prediction.
module object_position_tracker
  import tracker_pkg::*;
#(
  parameter int POS_W       = POS_W_DEFAULT,
  parameter int ALPHA_SHIFT = 2,
  parameter int ACQ_FRAMES  = 3,
  parameter int LOST_FRAMES = 8,
  parameter int MAX_JUMP    = 64
) (
  input  logic             iClk,
  input  logic             iRST,
  input  logic             iEN,
  input  logic             iFVAL,
  input  logic             iOBJ_VAL,
  input  logic [POS_W-1:0] iX_POS,
  input  logic [POS_W-1:0] iY_POS,
  output logic             oPOS_VAL,
  output logic [POS_W-1:0] oX_POS,
  output logic [POS_W-1:0] oY_POS,
  output logic             oLOCKED,
  output logic             oLOST,
  output logic [POS_W:0]   oX_VEL,
  output logic [POS_W:0]   oY_VEL
);

  localparam int HIT_W  = $clog2(ACQ_FRAMES + 1);
  localparam int MISS_W = $clog2(LOST_FRAMES + 1);
  localparam logic [HIT_W-1:0]  ACQ_TARGET  = HIT_W'(ACQ_FRAMES);
  localparam logic [MISS_W-1:0] LOST_TARGET = MISS_W'(LOST_FRAMES);

  trk_state_e state, stateNext;
  logic [HIT_W-1:0]  hitCnt, hitCntNext, hitInc;
  logic [MISS_W-1:0] missCnt, missCntNext, missInc;

  logic             fvalPrev, frameEnd, hitLatch;
  logic [POS_W-1:0] measX, measY;
  logic             evalPending, evalHit;
  logic [POS_W-1:0] evalX, evalY;
  logic             posPending, lostNext, gatedHit;
  logic             load, emaUpdate, velUpdate, predict, clearVel;
  logic             outlierX, outlierY;
  logic [POS_W-1:0] filtX, filtY;

  assign frameEnd = iEN & fvalPrev & ~iFVAL;
  assign hitInc   = hitCnt + HIT_W'(1);
  assign missInc  = missCnt + MISS_W'(1);
  assign oLOCKED  = (state == TRACK) || (state == COAST);

  // Collect the frame's last measurement; a strobe on the frame-end cycle still belongs to the closing frame.
  always_ff @(posedge iClk) begin
    if (iRST) begin
      fvalPrev    <= 1'b0;
      hitLatch    <= 1'b0;
      measX       <= '0;
      measY       <= '0;
      evalPending <= 1'b0;
      evalHit     <= 1'b0;
      evalX       <= '0;
      evalY       <= '0;
    end else if (iEN) begin
      fvalPrev    <= iFVAL;
      evalPending <= frameEnd;
      if (frameEnd) begin
        evalHit  <= hitLatch | iOBJ_VAL;
        evalX    <= iOBJ_VAL ? iX_POS : measX;
        evalY    <= iOBJ_VAL ? iY_POS : measY;
        hitLatch <= 1'b0;
      end else if (iOBJ_VAL) begin
        hitLatch <= 1'b1;
        measX    <= iX_POS;
        measY    <= iY_POS;
      end
    end
  end

  // Lock state machine: decides the next state and which filter action the frame's result triggers.
  always_comb begin
    stateNext   = state;
    hitCntNext  = hitCnt;
    missCntNext = missCnt;
    load        = 1'b0;
    emaUpdate   = 1'b0;
    velUpdate   = 1'b0;
    predict     = 1'b0;
    clearVel    = 1'b0;
    lostNext    = 1'b0;
    gatedHit    = evalHit & ~(outlierX | outlierY);
    if (evalPending) begin
      unique case (state)
        IDLE: begin
          if (evalHit) begin
            load       = 1'b1;
            hitCntNext = HIT_W'(1);
            stateNext  = (ACQ_TARGET == HIT_W'(1)) ? TRACK : ACQUIRE;
          end
        end
        ACQUIRE: begin
          if (evalHit) begin
            load       = 1'b1;
            hitCntNext = hitInc;
            if (hitInc >= ACQ_TARGET) begin
              stateNext = TRACK;
            end
          end else begin
            stateNext  = IDLE;
            hitCntNext = '0;
            clearVel   = 1'b1;
          end
        end
        TRACK: begin
          if (gatedHit) begin
            emaUpdate = 1'b1;
            velUpdate = 1'b1;
          end else begin
            stateNext   = COAST;
            missCntNext = MISS_W'(1);
            predict     = 1'b1;
          end
        end
        COAST: begin
          if (gatedHit) begin
            stateNext   = TRACK;
            missCntNext = '0;
            emaUpdate   = 1'b1;
          end else if (missInc >= LOST_TARGET) begin
            stateNext   = IDLE;
            missCntNext = '0;
            hitCntNext  = '0;
            clearVel    = 1'b1;
            lostNext    = 1'b1;
          end else begin
            missCntNext = missInc;
            predict     = 1'b1;
          end
        end
      endcase
    end
  end

  // State register, counters and the lost pulse, all frozen while the block is disabled.
  always_ff @(posedge iClk) begin
    if (iRST) begin
      state      <= IDLE;
      hitCnt     <= '0;
      missCnt    <= '0;
      oLOST      <= 1'b0;
      posPending <= 1'b0;
    end else if (iEN) begin
      state      <= stateNext;
      hitCnt     <= hitCntNext;
      missCnt    <= missCntNext;
      oLOST      <= lostNext;
      posPending <= evalPending && ((stateNext == TRACK) || (stateNext == COAST));
    end else begin
      oLOST      <= 1'b0;
    end
  end

  // Publish the freshly updated filter outputs one cycle after the state update.
  always_ff @(posedge iClk) begin
    if (iRST) begin
      oPOS_VAL <= 1'b0;
      oX_POS   <= '0;
      oY_POS   <= '0;
    end else if (iEN) begin
      oPOS_VAL <= posPending;
      if (posPending) begin
        oX_POS <= filtX;
        oY_POS <= filtY;
      end
    end else begin
      oPOS_VAL <= 1'b0;
    end
  end

  ema_axis_filter #(.POS_W(POS_W), .ALPHA_SHIFT(ALPHA_SHIFT), .MAX_JUMP(MAX_JUMP)) xFilter (
    .clock(iClk), .reset(iRST), .enable(iEN), .load(load), .emaUpdate(emaUpdate),
    .velUpdate(velUpdate), .predict(predict), .clearVel(clearVel), .meas(evalX),
    .outlier(outlierX), .filt(filtX), .vel(oX_VEL)
  );

  ema_axis_filter #(.POS_W(POS_W), .ALPHA_SHIFT(ALPHA_SHIFT), .MAX_JUMP(MAX_JUMP)) yFilter (
    .clock(iClk), .reset(iRST), .enable(iEN), .load(load), .emaUpdate(emaUpdate),
    .velUpdate(velUpdate), .predict(predict), .clearVel(clearVel), .meas(evalY),
    .outlier(outlierY), .filt(filtY), .vel(oY_VEL)
  );

endmodule

// File: tb/tb_object_position_tracker.sv
`timescale 1ns/1ps
// tb_object_position_tracker: frame-level bench for object_position_tracker with a directed
// vector table, hand-written corner sequences and a randomized phase against a frame-level model.
// VELOCITY_EST_EN, when defined for the build, also enables the velocity expectations.
module tb_object_position_tracker;

  localparam int POS_W       = 16;
  localparam int SHIFT       = 2;
  localparam int ACQ_N       = 3;
  localparam int LOST_N      = 8;
  localparam int JUMP        = 64;
  localparam int MAX_COORD   = 65535;
`ifdef VELOCITY_EST_EN
  localparam bit VEL_EN = 1'b1;
`else
  localparam bit VEL_EN = 1'b0;
`endif

  localparam int M_IDLE = 0, M_ACQ = 1, M_TRACK = 2, M_COAST = 3;

  typedef struct {
    bit hit;
    int x;
    int y;
    bit atEnd;
    bit decoy;
  } frameIn_t;

  typedef struct {
    int earlyValid;
    int locked;
    int lost;
    int midValid;
    int valid;
    int lateLost;
    int x;
    int y;
    int vx;
    int vy;
  } frameObs_t;

  typedef struct {
    frameIn_t in;
    int expLocked;
    int expLost;
    int expValid;
    int expX;
    int expY;
  } frameVec_t;

  logic clk = 1'b0;
  logic iRST, iEN, iFVAL, iOBJ_VAL;
  logic [POS_W-1:0] iX_POS, iY_POS;
  logic oPOS_VAL, oLOCKED, oLOST;
  logic [POS_W-1:0] oX_POS, oY_POS;
  logic [POS_W:0] oX_VEL, oY_VEL;

  int checks = 0;
  int errors = 0;

  // Frame-level reference: state name, filtered position, velocity, counters and held outputs.
  int mState, mFx, mFy, mVx, mVy, mHits, mMisses, mOutX, mOutY, mValid, mLost;

  always #5 clk = ~clk;

  object_position_tracker dut (
    .iClk(clk), .iRST(iRST), .iEN(iEN), .iFVAL(iFVAL), .iOBJ_VAL(iOBJ_VAL),
    .iX_POS(iX_POS), .iY_POS(iY_POS), .oPOS_VAL(oPOS_VAL), .oX_POS(oX_POS),
    .oY_POS(oY_POS), .oLOCKED(oLOCKED), .oLOST(oLOST), .oX_VEL(oX_VEL), .oY_VEL(oY_VEL)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int clampPos(input int v);
    if (v < 0) return 0;
    if (v > MAX_COORD) return MAX_COORD;
    return v;
  endfunction

  function automatic int floorDiv(input int d);
    int q;
    q = 1 << SHIFT;
    if (d >= 0) return d / q;
    return -((-d + q - 1) / q);
  endfunction

  function automatic int absVal(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic modelReset();
    mState = M_IDLE; mFx = 0; mFy = 0; mVx = 0; mVy = 0;
    mHits = 0; mMisses = 0; mOutX = 0; mOutY = 0; mValid = 0; mLost = 0;
  endtask

  task automatic modelPredict();
    if (VEL_EN) begin
      mFx = clampPos(mFx + mVx);
      mFy = clampPos(mFy + mVy);
    end
  endtask

  task automatic modelSmooth(input int mx, input int my, input bit keepVel);
    int nx, ny;
    nx = mFx + floorDiv(mx - mFx);
    ny = mFy + floorDiv(my - mFy);
    if (VEL_EN && keepVel) begin
      mVx = nx - mFx;
      mVy = ny - mFy;
    end
    mFx = nx;
    mFy = ny;
  endtask

  task automatic modelFrame(input frameIn_t f);
    bit near;
    near  = f.hit && absVal(f.x - mFx) <= JUMP && absVal(f.y - mFy) <= JUMP;
    mLost = 0;
    case (mState)
      M_IDLE: if (f.hit) begin
        mFx = f.x; mFy = f.y; mHits = 1;
        mState = (mHits >= ACQ_N) ? M_TRACK : M_ACQ;
      end
      M_ACQ: if (f.hit) begin
        mFx = f.x; mFy = f.y; mHits++;
        if (mHits >= ACQ_N) mState = M_TRACK;
      end else begin
        mState = M_IDLE; mHits = 0;
      end
      M_TRACK: if (near) begin
        modelSmooth(f.x, f.y, 1'b1);
      end else begin
        mState = M_COAST; mMisses = 1;
        modelPredict();
      end
      default: if (near) begin
        mState = M_TRACK; mMisses = 0;
        modelSmooth(f.x, f.y, 1'b0);
      end else if (mMisses + 1 >= LOST_N) begin
        mState = M_IDLE; mMisses = 0; mHits = 0; mVx = 0; mVy = 0; mLost = 1;
      end else begin
        mMisses++;
        modelPredict();
      end
    endcase
    mValid = (mState == M_TRACK || mState == M_COAST) ? 1 : 0;
    if (mValid != 0) begin
      mOutX = mFx;
      mOutY = mFy;
    end
  endtask

  // Drives one frame, then samples the outputs at the frame-end edge and the two edges after it.
  task automatic applyStimulus(input frameIn_t f, output frameObs_t o);
    @(negedge clk);
    iFVAL = 1'b1;
    for (int c = 0; c < 6; c++) begin
      iOBJ_VAL = 1'b0;
      if (f.hit && f.decoy && c == 1) begin
        iOBJ_VAL = 1'b1;
        iX_POS = POS_W'($urandom_range(0, 3000));
        iY_POS = POS_W'($urandom_range(0, 3000));
      end else if (f.hit && !f.atEnd && c == 3) begin
        iOBJ_VAL = 1'b1;
        iX_POS = POS_W'(f.x);
        iY_POS = POS_W'(f.y);
      end
      @(negedge clk);
    end
    iFVAL = 1'b0;
    iOBJ_VAL = f.hit && f.atEnd;
    if (f.hit && f.atEnd) begin
      iX_POS = POS_W'(f.x);
      iY_POS = POS_W'(f.y);
    end
    @(posedge clk); #1;
    o.earlyValid = int'(oPOS_VAL);
    @(negedge clk);
    iOBJ_VAL = 1'b0;
    @(posedge clk); #1;
    o.locked   = int'(oLOCKED);
    o.lost     = int'(oLOST);
    o.midValid = int'(oPOS_VAL);
    @(posedge clk); #1;
    o.valid    = int'(oPOS_VAL);
    o.lateLost = int'(oLOST);
    o.x        = int'(oX_POS);
    o.y        = int'(oY_POS);
    o.vx       = int'($signed(oX_VEL));
    o.vy       = int'($signed(oY_VEL));
    repeat (2) @(posedge clk);
  endtask

  task automatic runAndCompare(input frameIn_t f, input string tag);
    frameObs_t o;
    modelFrame(f);
    applyStimulus(f, o);
    checkOutput({tag, ".early"},  o.earlyValid, 0);
    checkOutput({tag, ".mid"},    o.midValid, 0);
    checkOutput({tag, ".locked"}, o.locked, (mState == M_TRACK || mState == M_COAST) ? 1 : 0);
    checkOutput({tag, ".lost"},   o.lost, mLost);
    checkOutput({tag, ".lost2"},  o.lateLost, 0);
    checkOutput({tag, ".valid"},  o.valid, mValid);
    checkOutput({tag, ".x"},      o.x, mOutX);
    checkOutput({tag, ".y"},      o.y, mOutY);
    checkOutput({tag, ".vx"},     o.vx, VEL_EN ? mVx : 0);
    checkOutput({tag, ".vy"},     o.vy, VEL_EN ? mVy : 0);
  endtask

  task automatic resetDut();
    @(negedge clk);
    iRST = 1'b1; iFVAL = 1'b0; iOBJ_VAL = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    iRST = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
  endtask

  function automatic frameIn_t mkFrame(input bit hit, input int x, input int y,
                                       input bit atEnd, input bit decoy);
    frameIn_t f;
    f.hit = hit; f.x = x; f.y = y; f.atEnd = atEnd; f.decoy = decoy;
    return f;
  endfunction

  initial begin
    frameVec_t vecs[16];
    frameObs_t o;
    frameIn_t f;
    int pulses;

    vecs[0]  = '{mkFrame(1, 100, 50, 0, 0), 0, 0, 0, 0,   0};
    vecs[1]  = '{mkFrame(1, 100, 50, 0, 1), 0, 0, 0, 0,   0};
    vecs[2]  = '{mkFrame(1, 100, 50, 1, 0), 1, 0, 1, 100, 50};
    vecs[3]  = '{mkFrame(1, 100, 50, 0, 0), 1, 0, 1, 100, 50};
    vecs[4]  = '{mkFrame(1, 300, 50, 0, 0), 1, 0, 1, 100, 50};
    vecs[5]  = '{mkFrame(1, 140, 50, 0, 1), 1, 0, 1, 110, 50};
    vecs[6]  = '{mkFrame(1, 110, 50, 1, 0), 1, 0, 1, 110, 50};
    for (int i = 7; i < 14; i++) vecs[i] = '{mkFrame(0, 0, 0, 0, 0), 1, 0, 1, 110, 50};
    vecs[14] = '{mkFrame(0, 0, 0, 0, 0), 0, 1, 0, 110, 50};
    vecs[15] = '{mkFrame(0, 0, 0, 0, 0), 0, 0, 0, 110, 50};

    iRST = 1'b1; iEN = 1'b1; iFVAL = 1'b0; iOBJ_VAL = 1'b0; iX_POS = '0; iY_POS = '0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst.valid",  int'(oPOS_VAL), 0);
    checkOutput("rst.x",      int'(oX_POS), 0);
    checkOutput("rst.y",      int'(oY_POS), 0);
    checkOutput("rst.locked", int'(oLOCKED), 0);
    checkOutput("rst.lost",   int'(oLOST), 0);
    checkOutput("rst.vx",     int'($signed(oX_VEL)), 0);
    @(negedge clk);
    iRST = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].in, o);
      checkOutput($sformatf("tbl%0d.early", i),  o.earlyValid, 0);
      checkOutput($sformatf("tbl%0d.locked", i), o.locked, vecs[i].expLocked);
      checkOutput($sformatf("tbl%0d.lost", i),   o.lost, vecs[i].expLost);
      checkOutput($sformatf("tbl%0d.valid", i),  o.valid, vecs[i].expValid);
      checkOutput($sformatf("tbl%0d.x", i),      o.x, vecs[i].expX);
      checkOutput($sformatf("tbl%0d.y", i),      o.y, vecs[i].expY);
    end

    // Reset in the middle of a coasting frame clears everything on the next edge.
    resetDut();
    for (int i = 0; i < 3; i++) runAndCompare(mkFrame(1, 500, 400, 0, 0), $sformatf("acqA%0d", i));
    runAndCompare(mkFrame(0, 0, 0, 0, 0), "coastA");
    @(negedge clk);
    iFVAL = 1'b1;
    @(negedge clk);
    iRST = 1'b1; iFVAL = 1'b0;
    @(posedge clk); #1;
    checkOutput("midRst.locked", int'(oLOCKED), 0);
    checkOutput("midRst.x",      int'(oX_POS), 0);
    checkOutput("midRst.y",      int'(oY_POS), 0);
    checkOutput("midRst.valid",  int'(oPOS_VAL), 0);
    @(negedge clk);
    iRST = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);

    // A whole frame with the block disabled must leave no trace.
    for (int i = 0; i < 3; i++) runAndCompare(mkFrame(1, 200, 200, 0, 0), $sformatf("acqB%0d", i));
    @(negedge clk);
    iEN = 1'b0;
    pulses = 0;
    iFVAL = 1'b1;
    for (int c = 0; c < 6; c++) begin
      iOBJ_VAL = (c == 2);
      iX_POS = POS_W'(260);
      iY_POS = POS_W'(200);
      @(posedge clk); #1;
      if (oPOS_VAL) pulses++;
      @(negedge clk);
    end
    iOBJ_VAL = 1'b0;
    iFVAL = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (oPOS_VAL) pulses++;
    end
    checkOutput("disabled.pulses", pulses, 0);
    checkOutput("disabled.locked", int'(oLOCKED), 1);
    @(negedge clk);
    iEN = 1'b1;
    runAndCompare(mkFrame(0, 0, 0, 0, 0), "afterDisable");

`ifdef VELOCITY_EST_EN
    // Velocity from one tracked step, then one predicted coast frame.
    resetDut();
    for (int i = 0; i < 3; i++) runAndCompare(mkFrame(1, 100, 50, 0, 0), $sformatf("velAcq%0d", i));
    applyStimulus(mkFrame(1, 104, 50, 0, 0), o);
    modelFrame(mkFrame(1, 104, 50, 0, 0));
    checkOutput("vel.trackX", o.x, 101);
    checkOutput("vel.trackVx", o.vx, 1);
    applyStimulus(mkFrame(0, 0, 0, 0, 0), o);
    modelFrame(mkFrame(0, 0, 0, 0, 0));
    checkOutput("vel.coastX", o.x, 102);
    checkOutput("vel.coastVx", o.vx, 1);
`endif

    // Randomized frames against the reference model.
    resetDut();
    for (int i = 0; i < 70; i++) begin
      f.hit   = ($urandom_range(0, 9) < 7);
      f.atEnd = ($urandom_range(0, 4) == 0);
      f.decoy = ($urandom_range(0, 3) == 0);
      if (mState == M_TRACK || mState == M_COAST) begin
        f.x = clampPos(mFx + int'($urandom_range(0, 180)) - 90);
        f.y = clampPos(mFy + int'($urandom_range(0, 180)) - 90);
      end else begin
        f.x = int'($urandom_range(100, 900));
        f.y = int'($urandom_range(100, 900));
      end
      runAndCompare(f, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
